bool_lut_sweeper: RTL
=====================

BOOL_LUT_SWEEPER -- requirements
Module: bool_lut_sweeper

Interface
REQ-001 The module SHALL have parameter N_IN, default 4, giving the number of boolean inputs; legal range 2..8.
REQ-002 The module SHALL have parameter TBL_W, default 2**N_IN, giving the truth-table width; it is derived and not overridden.
REQ-003 Port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 Port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-005 Port cfg_we, input, 1 bit: truth-table bit write strobe.
REQ-006 Port cfg_addr, input, N_IN bits: minterm index to write.
REQ-007 Port cfg_data, input, 1 bit: function value for cfg_addr.
REQ-008 Port in_vec, input, N_IN bits: evaluation input vector; MSB is the first literal (A).
REQ-009 Port f_out, output, 1 bit: registered function value of in_vec.
REQ-010 Port start, input, 1 bit: single-cycle sweep request.
REQ-011 Port busy, output, 1 bit: sweep in progress.
REQ-012 Port done, output, 1 bit: one-cycle pulse when a sweep ends.
REQ-013 Port sweep_vec, output, N_IN bits: current sweep minterm, driven to an external combinational DUT.
REQ-014 Port sweep_valid, output, 1 bit: sweep_vec is valid this cycle.
REQ-015 Port dut_f, input, 1 bit: external DUT response to sweep_vec, sampled in the same cycle.
REQ-016 Port ones_count, output, N_IN+1 bits: number of minterms whose table bit is 1.
REQ-017 Port mismatch_count, output, N_IN+1 bits: number of vectors where dut_f differed from the table.
REQ-018 Port first_mismatch_vec, output, N_IN bits: lowest sweep_vec that mismatched.

Function
REQ-019 Truth table write: when cfg_we=1 and the block is not busy, table[cfg_addr] SHALL take cfg_data at the clock edge.
REQ-020 A cfg_we asserted while busy=1 SHALL be ignored.
REQ-021 Evaluation: f_out SHALL equal table[in_vec] one cycle after in_vec is applied, in every state.
REQ-022 State machine: the states SHALL be IDLE, SWEEP and DONE.
- IDLE to SWEEP on start=1.
- SWEEP to DONE after vector 2**N_IN-1.
- DONE to IDLE unconditionally after one cycle.
REQ-023 On entry to SWEEP:
- sweep_vec SHALL be 0.
- ones_count, mismatch_count and first_mismatch_vec SHALL be cleared.
REQ-024 In SWEEP, sweep_valid SHALL be 1 and sweep_vec SHALL increment by 1 per cycle; a sweep lasts exactly 2**N_IN cycles.
REQ-025 Each SWEEP cycle, ones_count SHALL add table[sweep_vec].
REQ-026 Each SWEEP cycle, mismatch_count SHALL add (dut_f XOR table[sweep_vec]).
REQ-027 Counters SHALL be N_IN+1 bits, so the all-ones table (count 2**N_IN) does not wrap.
REQ-028 first_mismatch_vec SHALL capture sweep_vec on the first mismatch only; it remains 0 if no mismatch occurs.
REQ-029 busy SHALL be 1 in SWEEP and DONE.
REQ-030 done SHALL be 1 only in DONE.
REQ-031 Result outputs SHALL hold their values from DONE until the next sweep starts.
REQ-032 A start while busy SHALL be ignored; start coincident with cfg_we in IDLE SHALL perform the write, then sweep the updated table.
REQ-033 sweep_vec SHALL not wrap past 2**N_IN-1 within a sweep, and SHALL hold its final value after the sweep.

Reset
REQ-034 On rst_n=0, regardless of clock:
- state SHALL be IDLE.
- busy, done, sweep_valid and f_out SHALL be 0.
- sweep_vec, all counts and first_mismatch_vec SHALL be 0.
- the truth table SHALL be all zeros.
REQ-035 Reset asserted mid-sweep SHALL abort the sweep with no done pulse.

Configuration
REQ-036 Macro BOOL_LUT_CHECK_EN defined: the dut_f comparison (REQ-026, REQ-028) SHALL be compiled in.
REQ-037 Macro BOOL_LUT_CHECK_EN undefined: mismatch_count and first_mismatch_vec SHALL be constant 0, and dut_f SHALL be unused.

Structure
REQ-038 Package bool_lut_pkg SHALL hold:
- the state enumeration (IDLE, SWEEP, DONE).
- the default N_IN constant.
- a count-width function returning N_IN+1.
REQ-039 Sub-module bool_lut_table SHALL hold the table storage, with one write port and two read ports (in_vec and sweep_vec).

Verification
REQ-040 N_IN=4; load table 16'h000C (F = NOT(A OR B OR NOT C), minterms 2 and 3) -> after 16 sweep cycles, ones_count=2 and done pulses once.
REQ-041 Same table; dut_f driven by a correct model -> mismatch_count=0, first_mismatch_vec=0.
REQ-042 Same table; dut_f stuck at 0 -> mismatch_count=2, first_mismatch_vec=4'h2; with the macro undefined, both are 0.
REQ-043 Evaluation: in_vec=4'b0011 -> f_out=1 on the next cycle; in_vec=4'b0111 -> f_out=0.
REQ-044 Reset when sweep_vec=5 -> busy=0, counts=0, no done; a later start gives a full 16-cycle sweep.
REQ-045 Start pulse and cfg_we at cycle 3 of a sweep -> both ignored; table bit unchanged; sweep length still 16.

Source files
------------

// File: rtl/bool_lut_pkg.sv
// bool_lut_pkg: shared state enumeration, default input count and counter-width helper
package bool_lut_pkg;
  typedef enum logic [1:0] {IDLE, SWEEP, DONE} state_t;
  localparam int N_IN_DEF = 4;
  function automatic int cnt_w(input int n);
    return n + 1;
  endfunction
endpackage

// File: rtl/bool_lut_table.sv
// bool_lut_table: truth-table storage with one write port and two combinational read ports
module bool_lut_table
  import bool_lut_pkg::*;
#(
  parameter int N_IN  = N_IN_DEF,
  parameter int TBL_W = 2**N_IN
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            i_we,
  input  logic [N_IN-1:0] i_addr,
  input  logic            i_data,
  input  logic [N_IN-1:0] i_ra,
  input  logic [N_IN-1:0] i_rb,
  output logic            o_rd_a,
  output logic            o_rd_b
);
  logic [TBL_W-1:0] r_tbl;
  // one table bit per minterm, cleared to the constant-0 function on reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_tbl <= '0;
    else if (i_we) r_tbl[i_addr] <= i_data;
  end
  assign o_rd_a = r_tbl[i_ra];
  assign o_rd_b = r_tbl[i_rb];
endmodule

// File: rtl/bool_lut_sweeper.sv
// bool_lut_sweeper: programmable truth table with registered evaluation and an exhaustive
// sweep that counts ones and, when BOOL_LUT_CHECK_EN is defined, checks an external DUT
module bool_lut_sweeper
  import bool_lut_pkg::*;
#(
  parameter int N_IN  = N_IN_DEF,
  parameter int TBL_W = 2**N_IN
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    cfg_we,
  input  logic [N_IN-1:0]         cfg_addr,
  input  logic                    cfg_data,
  input  logic [N_IN-1:0]         in_vec,
  output logic                    f_out,
  input  logic                    start,
  output logic                    busy,
  output logic                    done,
  output logic [N_IN-1:0]         sweep_vec,
  output logic                    sweep_valid,
  input  logic                    dut_f,
  output logic [cnt_w(N_IN)-1:0]  ones_count,
  output logic [cnt_w(N_IN)-1:0]  mismatch_count,
  output logic [N_IN-1:0]         first_mismatch_vec
);
  localparam int CW = cnt_w(N_IN);
  localparam logic [N_IN-1:0] LAST = '1;
  state_t          r_state;
  logic            r_busy, r_done, r_valid, r_f;
  logic [N_IN-1:0] r_vec;
  logic [CW-1:0]   r_ones;
  logic            w_tbl_a, w_tbl_s;
  logic            w_go;
  assign w_go = (r_state == IDLE) && start;
  bool_lut_table #(.N_IN(N_IN), .TBL_W(TBL_W)) u_tbl (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_we   (cfg_we && !r_busy),
    .i_addr (cfg_addr),
    .i_data (cfg_data),
    .i_ra   (in_vec),
    .i_rb   (r_vec),
    .o_rd_a (w_tbl_a),
    .o_rd_b (w_tbl_s)
  );
  // registered evaluation of in_vec, independent of the sweep state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_f <= 1'b0;
    else r_f <= w_tbl_a;
  end
  // sweep controller: walks every minterm once, accumulating the ones count
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_valid <= 1'b0;
      r_vec   <= '0;
      r_ones  <= '0;
    end else begin
      case (r_state)
        IDLE: if (start) begin
          r_state <= SWEEP;
          r_busy  <= 1'b1;
          r_valid <= 1'b1;
          r_vec   <= '0;
          r_ones  <= '0;
        end
        SWEEP: begin
          r_ones <= r_ones + CW'(w_tbl_s);
          if (r_vec == LAST) begin
            r_state <= DONE;
            r_valid <= 1'b0;
            r_done  <= 1'b1;
          end else r_vec <= r_vec + N_IN'(1);
        end
        DONE: begin
          r_state <= IDLE;
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
`ifdef BOOL_LUT_CHECK_EN
  logic [CW-1:0]   r_mis;
  logic [N_IN-1:0] r_first;
  logic            w_mm;
  assign w_mm = dut_f ^ w_tbl_s;
  // compare the external DUT against the table; an empty count marks the first miss
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mis   <= '0;
      r_first <= '0;
    end else if (w_go) begin
      r_mis   <= '0;
      r_first <= '0;
    end else if (r_state == SWEEP) begin
      r_mis <= r_mis + CW'(w_mm);
      if (w_mm && r_mis == '0) r_first <= r_vec;
    end
  end
  assign mismatch_count     = r_mis;
  assign first_mismatch_vec = r_first;
`else
  logic w_unused;
  assign w_unused           = dut_f ^ w_go;
  assign mismatch_count     = '0;
  assign first_mismatch_vec = '0;
`endif
  assign f_out       = r_f;
  assign busy        = r_busy;
  assign done        = r_done;
  assign sweep_vec   = r_vec;
  assign sweep_valid = r_valid;
  assign ones_count  = r_ones;
endmodule
